// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and the round-robin search used by the 4-way arbiter.
// The search rotates the request vector so the slot after the pointer is bit 0, then picks the lowest set bit.
package rr_arbiter_4_pkg;

   localparam int NREQ = 4;
   localparam int IW   = 2;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic          valid;
      logic [IW-1:0] idx;
   } pick_t;

   // rotate, priority-encode, un-rotate
   function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                     input logic [IW-1:0]   ptr);
      logic [NREQ-1:0] rot;
      logic [IW-1:0]   base;
      logic [IW-1:0]   off;
      pick_t           p;
      base = ptr + 2'd1;
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = req[base + IW'(i)];
      end
      off = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (rot[i]) off = IW'(i);
      end
      p.valid = |rot;
      p.idx   = base + off;
      return p;
   endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 decoder with enable; x=00 drives y[3], x=11 drives y[0].
module decoder_2_4
   import rr_arbiter_4_pkg::*;
(
   input  logic [IW-1:0]   x,
   input  logic            en,
   output logic [NREQ-1:0] y
);

   always_comb begin
      y = '0;
      if (en) y[2'd3 - x] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with done/drop release and optional hold-time limit.
// gnt_idx doubles as the round-robin pointer, so it is kept after release.
//
// state   | meaning
// S_IDLE  | no owner; arbitrate among req each cycle
// S_GRANT | gnt_idx owns the resource; watch done, req drop and hold limit
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int CW       = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            busy,
   output logic            timeout
);

   localparam bit          HOLD_EN   = (HOLD_MAX != 0);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

   state_t        state, state_nxt;
   logic [IW-1:0] gnt_idx_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          timeout_nxt;
   logic          rel_owner;
   logic          rel_hold;
   pick_t         pick;

   assign pick = rr_pick(req, gnt_idx);

   always_comb begin
      state_nxt   = state;
      gnt_idx_nxt = gnt_idx;
      cnt_nxt     = cnt;
      timeout_nxt = 1'b0;
      rel_owner   = done | ~req[gnt_idx];
      rel_hold    = HOLD_EN && (cnt == HOLD_LAST);
      case (state)
         S_IDLE: begin
            if (pick.valid) begin
               gnt_idx_nxt = pick.idx;
               cnt_nxt     = '0;
               state_nxt   = S_GRANT;
            end
         end
         S_GRANT: begin
            if (rel_owner || rel_hold) begin
               state_nxt   = S_IDLE;
               // timeout only when the hold limit is the sole cause
               timeout_nxt = rel_hold & ~rel_owner;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         gnt_idx <= 2'b11;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt_idx <= gnt_idx_nxt;
         cnt     <= cnt_nxt;
         timeout <= timeout_nxt;
      end
   end

   assign busy = (state == S_GRANT);

   decoder_2_4 u_gnt_dec (
      .x  (~gnt_idx),
      .en (busy),
      .y  (gnt)
   );

endmodule
